// File: rtl/slot_alloc_8.sv
// ---------------------------------------------------------------------------
// slot_alloc_8
//
// Purpose:
//   Eight-slot allocation tracker for the switch's free-slot bitmap. It grants
//   the lowest-numbered free slot one cycle after a request. It also accepts
//   released slot indices and clears them from the occupancy bitmap.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   alloc_req  in   request one slot this cycle
//   alloc_vld  out  one-cycle pulse answering last cycle's alloc_req
//   alloc_idx  out  granted slot 0..7, or 8 when nothing was free
//   alloc_fail out  pulses with alloc_vld when alloc_idx is 8
//   rel_valid  in   release one slot this cycle
//   rel_idx    in   slot being released
//   rel_err    out  pulse for an out-of-range or double release
//   occ        out  occupancy bitmap, bit i = 1 means slot i is in use
//   free_cnt   out  number of free slots, 0..8
//   full       out  no free slots
//   empty      out  every slot free
// ---------------------------------------------------------------------------
module slot_alloc_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       alloc_req,
    output logic       alloc_vld,
    output logic [3:0] alloc_idx,
    output logic       alloc_fail,
    input  logic       rel_valid,
    input  logic [3:0] rel_idx,
    output logic       rel_err,
    output logic [7:0] occ,
    output logic [3:0] free_cnt,
    output logic       full,
    output logic       empty
);

    // The index encoding reserves value 8 for "none free", so the slot count is fixed.
    localparam int SLOTS = 8;
    localparam logic [3:0] NONE_FREE = 4'd8;

    logic [7:0] occ_q, occ_d;
    logic [3:0] free_cnt_q, free_cnt_d;
    logic       full_q, full_d;
    logic       empty_q, empty_d;
    logic       alloc_vld_q, alloc_vld_d;
    logic       alloc_fail_q, alloc_fail_d;
    logic [3:0] alloc_idx_q, alloc_idx_d;
    logic       rel_err_q, rel_err_d;

    logic [3:0] first_free;
    logic       alloc_ok;
    logic       rel_ok;

    // Lowest-numbered free slot in the bitmap as registered at the start of the
    // cycle. Scanning downward lets the lowest zero win the last assignment.
    always_comb begin
        first_free = NONE_FREE;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                first_free = 4'(i);
            end
        end
    end

    // Grant and release both look at the pre-update bitmap. A valid release
    // always targets an occupied bit, while a grant always targets a free bit,
    // so the two bitmap updates never collide.
    always_comb begin
        alloc_ok = alloc_req && (first_free != NONE_FREE);
        rel_ok   = rel_valid && (rel_idx < NONE_FREE) && occ_q[rel_idx[2:0]];

        occ_d = occ_q;
        if (alloc_ok) begin
            occ_d[first_free[2:0]] = 1'b1;
        end
        if (rel_ok) begin
            occ_d[rel_idx[2:0]] = 1'b0;
        end

        free_cnt_d = free_cnt_q;
        if (alloc_ok && !rel_ok) begin
            free_cnt_d = free_cnt_q - 4'd1;
        end else if (rel_ok && !alloc_ok) begin
            free_cnt_d = free_cnt_q + 4'd1;
        end
        full_d  = (free_cnt_d == 4'd0);
        empty_d = (free_cnt_d == 4'd8);

        // The grant index holds its last value when there is no request.
        alloc_vld_d  = alloc_req;
        alloc_fail_d = alloc_req && (first_free == NONE_FREE);
        alloc_idx_d  = alloc_req ? first_free : alloc_idx_q;
        rel_err_d    = rel_valid && !rel_ok;
    end

    // All state and outputs are registered; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q        <= 8'h00;
            free_cnt_q   <= 4'd8;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            alloc_vld_q  <= 1'b0;
            alloc_fail_q <= 1'b0;
            alloc_idx_q  <= NONE_FREE;
            rel_err_q    <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            free_cnt_q   <= free_cnt_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            alloc_vld_q  <= alloc_vld_d;
            alloc_fail_q <= alloc_fail_d;
            alloc_idx_q  <= alloc_idx_d;
            rel_err_q    <= rel_err_d;
        end
    end

    assign occ        = occ_q;
    assign free_cnt   = free_cnt_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign alloc_vld  = alloc_vld_q;
    assign alloc_fail = alloc_fail_q;
    assign alloc_idx  = alloc_idx_q;
    assign rel_err    = rel_err_q;

endmodule

// File: tb/tb_slot_alloc_8.sv
// ---------------------------------------------------------------------------
// tb_slot_alloc_8
//
// Purpose:
//   Self-checking bench for slot_alloc_8. A slot-array reference model
//   predicts every registered output after each clock edge. It is driven by
//   directed scenarios followed by random alloc/release traffic.
// ---------------------------------------------------------------------------
module tb_slot_alloc_8;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_vld;
    logic [3:0] alloc_idx;
    logic       alloc_fail;
    logic       rel_valid;
    logic [3:0] rel_idx;
    logic       rel_err;
    logic [7:0] occ;
    logic [3:0] free_cnt;
    logic       full;
    logic       empty;

    int errors = 0;
    int checks = 0;

    // Reference model state: one flag per slot plus the expected output registers.
    bit occ_m[8];
    int exp_idx;
    bit exp_vld;
    bit exp_fail;
    bit exp_err;

    slot_alloc_8 dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_vld  (alloc_vld),
        .alloc_idx  (alloc_idx),
        .alloc_fail (alloc_fail),
        .rel_valid  (rel_valid),
        .rel_idx    (rel_idx),
        .rel_err    (rel_err),
        .occ        (occ),
        .free_cnt   (free_cnt),
        .full       (full),
        .empty      (empty)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: it counts the check and reports any miss.
    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Packs the per-slot model flags into a bitmap for comparison.
    function automatic logic [7:0] model_bitmap();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = occ_m[i];
        return b;
    endfunction

    // Counts free slots in the model.
    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < 8; i++) if (!occ_m[i]) n++;
        return n;
    endfunction

    // Applies one cycle of inputs to the model using the bitmap from before the edge.
    task automatic model_step(input bit r, input bit req, input bit rv, input int ri);
        int  lowest;
        bit  rel_ok;
        if (r) begin
            for (int i = 0; i < 8; i++) occ_m[i] = 0;
            exp_idx  = 8;
            exp_vld  = 0;
            exp_fail = 0;
            exp_err  = 0;
        end else begin
            lowest = 8;
            for (int i = 0; i < 8; i++) begin
                if (!occ_m[i]) begin
                    lowest = i;
                    break;
                end
            end
            rel_ok   = rv && (ri < 8) && occ_m[ri % 8];
            exp_err  = rv && !rel_ok;
            exp_vld  = req;
            exp_fail = req && (lowest == 8);
            if (req) exp_idx = lowest;
            if (req && lowest < 8) occ_m[lowest] = 1;
            if (rel_ok) occ_m[ri] = 0;
        end
    endtask

    // Compares every DUT output against the model.
    task automatic checkOutput(input string tag);
        int fc;
        fc = model_free();
        chk({tag, ".occ"},        32'(occ),        32'(model_bitmap()));
        chk({tag, ".free_cnt"},   32'(free_cnt),   32'(fc));
        chk({tag, ".full"},       32'(full),       32'(fc == 0));
        chk({tag, ".empty"},      32'(empty),      32'(fc == 8));
        chk({tag, ".alloc_vld"},  32'(alloc_vld),  32'(exp_vld));
        chk({tag, ".alloc_fail"}, 32'(alloc_fail), 32'(exp_fail));
        chk({tag, ".alloc_idx"},  32'(alloc_idx),  32'(exp_idx));
        chk({tag, ".rel_err"},    32'(rel_err),    32'(exp_err));
    endtask

    // Drives one cycle of inputs, advances the model, and checks after the edge.
    task automatic applyStimulus(input string tag, input bit r, input bit req, input bit rv, input int ri);
        rst       = r;
        alloc_req = req;
        rel_valid = rv;
        rel_idx   = 4'(ri);
        model_step(r, req, rv, ri);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        bit r, req, rv;
        int ri;

        rst       = 1'b1;
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        rel_idx   = 4'd0;

        // Reset state, with requests during reset being dropped.
        applyStimulus("reset0", 1, 0, 0, 0);
        applyStimulus("reset1", 1, 1, 1, 3);
        chk("reset_idx_none", 32'(alloc_idx), 32'd8);

        // Fill all eight slots in ascending order, then overflow.
        for (int i = 0; i < 8; i++) begin
            applyStimulus("fill", 0, 1, 0, 0);
            chk("fill_grant_order", 32'(alloc_idx), 32'(i));
        end
        chk("fill_occ_ff", 32'(occ), 32'hFF);
        chk("fill_full", 32'(full), 32'd1);
        applyStimulus("overflow", 0, 1, 0, 0);
        chk("overflow_fail", 32'(alloc_fail), 32'd1);
        applyStimulus("idle_hold", 0, 0, 0, 0);

        // Release 5 then 2, and the holes come back lowest first.
        applyStimulus("rel5", 0, 0, 1, 5);
        applyStimulus("rel2", 0, 0, 1, 2);
        chk("holes_occ_db", 32'(occ), 32'hDB);
        applyStimulus("reuse_a", 0, 1, 0, 0);
        chk("reuse_first_2", 32'(alloc_idx), 32'd2);
        applyStimulus("reuse_b", 0, 1, 0, 0);
        chk("reuse_second_5", 32'(alloc_idx), 32'd5);

        // Simultaneous grant and release starting from 0x0F.
        applyStimulus("rst_sim", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus("prep0f", 0, 1, 0, 0);
        applyStimulus("simul", 0, 1, 1, 1);
        chk("simul_idx_4", 32'(alloc_idx), 32'd4);
        chk("simul_occ_1d", 32'(occ), 32'h1D);
        chk("simul_free_4", 32'(free_cnt), 32'd4);

        // Double release and out-of-range release.
        applyStimulus("err_double", 0, 0, 1, 6);
        applyStimulus("err_range", 0, 0, 1, 9);
        chk("err_occ_kept", 32'(occ), 32'h1D);
        applyStimulus("err_clear", 0, 0, 0, 0);

        // Reset while a burst of requests is in progress.
        applyStimulus("rst_burst", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("burst", 0, 1, 0, 0);
        chk("burst_occ_07", 32'(occ), 32'h07);
        applyStimulus("burst_rst", 1, 1, 0, 0);
        chk("burst_rst_vld", 32'(alloc_vld), 32'd0);
        applyStimulus("after_rst", 0, 1, 0, 0);
        chk("after_rst_idx0", 32'(alloc_idx), 32'd0);

        // Random soak: model comparison plus the free-count invariant every cycle.
        for (int n = 0; n < 10000; n++) begin
            r   = ($urandom_range(0, 999) == 0);
            req = ($urandom_range(0, 99) < 45);
            rv  = ($urandom_range(0, 99) < 45);
            ri  = $urandom_range(0, 9);
            applyStimulus("soak", r, req, rv, ri);
            chk("soak_invariant", 32'(free_cnt), 32'(8 - $countones(occ)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
